// File: rtl/spi_slave_regfile.sv
// SPI mode-0 responder with a small 32-bit register file.
// Frame: 8-bit command, 24-bit address, 32-bit data, MSB first.
// All SPI pins are oversampled in the clk_i domain; there are no SPI-clocked flops.
module spi_slave_regfile #(
    parameter int          DEPTH  = 16,
    parameter int          AW     = 4,
    parameter logic [7:0]  CMD_WR = 8'h02,
    parameter logic [7:0]  CMD_RD = 8'h03
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          sclk_i,
    input  logic          cs_n_i,
    input  logic          mosi_i,
    output logic          miso_o,
    output logic          frame_done_o,
    output logic          busy_o,
    output logic [7:0]    last_cmd_o,
    output logic [23:0]   last_addr_o,
    input  logic [AW-1:0] loc_addr_i,
    output logic [31:0]   loc_rdata_o
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        DONE
    } state_e;

    // Synchroniser and edge-detect flops
    logic sclkMeta_q, sclkSync_q, sclkPrev_q;
    logic csMeta_q, csSync_q;
    logic mosiMeta_q, mosiSync_q;

    // Frame state
    state_e      state_q, state_d;
    logic [6:0]  bitCnt_q, bitCnt_d;
    logic [31:0] shiftIn_q, shiftIn_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [23:0] addr_q, addr_d;
    logic        addrOk_q, addrOk_d;
    logic [31:0] outShift_q, outShift_d;
    logic        miso_q, miso_d;
    logic        frameDone_q, frameDone_d;
    logic        busy_q, busy_d;
    logic [7:0]  lastCmd_q, lastCmd_d;
    logic [23:0] lastAddr_q, lastAddr_d;

    // Register file
    logic [31:0] mem_q [DEPTH];
    logic        memWe;

    // Helpers derived from the synchronised pins
    logic        sclkRise, sclkFall;
    logic [31:0] shiftNext;
    logic [23:0] addrNext;
    logic        addrNextOk;
    logic [31:0] rdWord;

    assign sclkRise   = sclkSync_q & ~sclkPrev_q;
    assign sclkFall   = ~sclkSync_q & sclkPrev_q;
    assign shiftNext  = {shiftIn_q[30:0], mosiSync_q};
    assign addrNext   = shiftNext[23:0];
    assign addrNextOk = (addrNext[23:AW] == '0);
    assign rdWord     = addrNextOk ? mem_q[addrNext[AW-1:0]] : 32'h0;

    // Two-flop synchronisers for all SPI pins plus one extra sclk flop for edges
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclkMeta_q <= 1'b0;
            sclkSync_q <= 1'b0;
            sclkPrev_q <= 1'b0;
            csMeta_q   <= 1'b1;
            csSync_q   <= 1'b1;
            mosiMeta_q <= 1'b0;
            mosiSync_q <= 1'b0;
        end else begin
            sclkMeta_q <= sclk_i;
            sclkSync_q <= sclkMeta_q;
            sclkPrev_q <= sclkSync_q;
            csMeta_q   <= cs_n_i;
            csSync_q   <= csMeta_q;
            mosiMeta_q <= mosi_i;
            mosiSync_q <= mosiMeta_q;
        end
    end

    // Frame state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            bitCnt_q    <= '0;
            shiftIn_q   <= '0;
            cmd_q       <= '0;
            addr_q      <= '0;
            addrOk_q    <= 1'b0;
            outShift_q  <= '0;
            miso_q      <= 1'b0;
            frameDone_q <= 1'b0;
            busy_q      <= 1'b0;
            lastCmd_q   <= '0;
            lastAddr_q  <= '0;
        end else begin
            state_q     <= state_d;
            bitCnt_q    <= bitCnt_d;
            shiftIn_q   <= shiftIn_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            addrOk_q    <= addrOk_d;
            outShift_q  <= outShift_d;
            miso_q      <= miso_d;
            frameDone_q <= frameDone_d;
            busy_q      <= busy_d;
            lastCmd_q   <= lastCmd_d;
            lastAddr_q  <= lastAddr_d;
        end
    end

    // Next-state logic: bit counting, field capture, read shifting and frame completion
    always_comb begin
        state_d     = state_q;
        bitCnt_d    = bitCnt_q;
        shiftIn_d   = shiftIn_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        addrOk_d    = addrOk_q;
        outShift_d  = outShift_q;
        miso_d      = miso_q;
        frameDone_d = 1'b0;
        lastCmd_d   = lastCmd_q;
        lastAddr_d  = lastAddr_q;
        memWe       = 1'b0;

        case (state_q)
            IDLE: begin
                if (!csSync_q) begin
                    state_d  = CMD;
                    bitCnt_d = '0;
                end
            end
            CMD, ADDR, DATA: begin
                if (csSync_q) begin
                    // Chip select released early: abandon the frame with no side effects
                    state_d  = IDLE;
                    bitCnt_d = '0;
                end else if (sclkRise) begin
                    shiftIn_d = shiftNext;
                    bitCnt_d  = bitCnt_q + 7'd1;
                    if (state_q == CMD && bitCnt_q == 7'd7) begin
                        cmd_d   = shiftNext[7:0];
                        state_d = ADDR;
                    end else if (state_q == ADDR && bitCnt_q == 7'd31) begin
                        addr_d   = addrNext;
                        addrOk_d = addrNextOk;
                        state_d  = DATA;
                        if (cmd_q == CMD_RD) begin
                            outShift_d = rdWord;
                            miso_d     = rdWord[31];
                        end
                    end else if (state_q == DATA && bitCnt_q == 7'd63) begin
                        state_d     = DONE;
                        memWe       = (cmd_q == CMD_WR) && addrOk_q;
                        frameDone_d = 1'b1;
                        lastCmd_d   = cmd_q;
                        lastAddr_d  = addr_q;
                    end
                end else if (sclkFall && state_q == DATA && bitCnt_q >= 7'd33 &&
                             cmd_q == CMD_RD) begin
                    // The falling edge right after address bit 32 is skipped so that
                    // the MSB loaded on that rising edge is still on miso for bit 33
                    outShift_d = {outShift_q[30:0], 1'b0};
                    miso_d     = outShift_q[30];
                end
            end
            DONE: begin
                if (csSync_q) begin
                    state_d  = IDLE;
                    bitCnt_d = '0;
                end
            end
            default: begin
                state_d  = IDLE;
                bitCnt_d = '0;
            end
        endcase

        // miso is only ever driven during the data phase of a read frame
        if (state_d != DATA || cmd_q != CMD_RD) begin
            miso_d = 1'b0;
        end
        busy_d = (state_d != IDLE);
    end

    // Register file storage; a completed in-range write frame updates one word
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (memWe) begin
            mem_q[addr_q[AW-1:0]] <= shiftNext;
        end
    end

    assign loc_rdata_o  = mem_q[loc_addr_i];
    assign miso_o       = miso_q;
    assign frame_done_o = frameDone_q;
    assign busy_o       = busy_q;
    assign last_cmd_o   = lastCmd_q;
    assign last_addr_o  = lastAddr_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Bench for spi_slave_regfile: bit-banged SPI master, word-level register model,
// per-cycle idle comparison plus literal expectations.
module tb_spi_slave_regfile;

    logic        clk;
    logic        rst_n;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic        frameDone;
    logic        busy;
    logic [7:0]  lastCmd;
    logic [23:0] lastAddr;
    logic [3:0]  locAddr;
    logic [31:0] locRdata;

    int checks   = 0;
    int failures = 0;
    int doneCount = 0;
    int checkMode = 0;

    logic [31:0] modelMem [16];
    logic [7:0]  modelLastCmd;
    logic [23:0] modelLastAddr;

    logic [63:0] cap;

    spi_slave_regfile #(
        .DEPTH(16),
        .AW(4),
        .CMD_WR(8'h02),
        .CMD_RD(8'h03)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .sclk_i(sclk),
        .cs_n_i(cs_n),
        .mosi_i(mosi),
        .miso_o(miso),
        .frame_done_o(frameDone),
        .busy_o(busy),
        .last_cmd_o(lastCmd),
        .last_addr_o(lastAddr),
        .loc_addr_i(locAddr),
        .loc_rdata_o(locRdata)
    );

    // 50 MHz system clock
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Single comparison point: counts and reports
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Count frame_done pulses (one clk wide, so seen exactly once per pulse)
    always @(negedge clk) begin
        if (frameDone === 1'b1) doneCount++;
    end

    // Per-cycle compare against the model while the link is idle or in reset
    always begin
        @(negedge clk);
        #2;
        if (checkMode == 1) begin
            checkOutput("loc_rdata", {32'h0, locRdata}, {32'h0, modelMem[locAddr]});
            checkOutput("busy_idle", {63'h0, busy}, 64'h0);
            checkOutput("miso_idle", {63'h0, miso}, 64'h0);
            checkOutput("done_idle", {63'h0, frameDone}, 64'h0);
            checkOutput("last_cmd", {56'h0, lastCmd}, {56'h0, modelLastCmd});
            checkOutput("last_addr", {40'h0, lastAddr}, {40'h0, modelLastAddr});
        end else if (checkMode == 2) begin
            checkOutput("rst_loc_rdata", {32'h0, locRdata}, 64'h0);
            checkOutput("rst_outputs", {22'h0, miso, frameDone, busy, lastCmd, lastAddr}, 64'h0);
        end
    end

    // Drive one SPI frame of nbits clocks; capture miso on every rising edge
    task automatic applyStimulus(input logic [7:0] cmd, input logic [23:0] addr,
                                 input logic [31:0] data, input int nbits,
                                 input int gapClk, input bit keepCs,
                                 output logic [63:0] captured);
        logic [63:0] word;
        logic [31:0] expRd;
        int          doneStart;
        bit          complete;
        word      = {cmd, addr, data};
        captured  = '0;
        complete  = (nbits >= 64);
        expRd     = (cmd == 8'h03 && addr < 24'd16) ? modelMem[addr[3:0]] : 32'h0;
        checkMode = 0;
        doneStart = doneCount;
        @(negedge clk);
        cs_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 64) ? word[63-i] : 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            if (i < 64) captured[63-i] = miso;
            if (i == 0) checkOutput("busy_mid", {63'h0, busy}, 64'h1);
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        if (keepCs) return;
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("frame_done_count", 64'(doneCount - doneStart), complete ? 64'd1 : 64'd0);
        if (complete) begin
            checkOutput("miso_hdr", captured[63:32], 64'h0);
            checkOutput("miso_data", {32'h0, captured[31:0]}, {32'h0, expRd});
            if (cmd == 8'h02 && addr < 24'd16) modelMem[addr[3:0]] = data;
            modelLastCmd  = cmd;
            modelLastAddr = addr;
        end
        checkMode = 1;
        for (int g = 0; g < gapClk; g++) begin
            @(negedge clk);
            locAddr = locAddr + 4'd1;
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 16; i++) modelMem[i] = 32'h0;
        modelLastCmd  = 8'h0;
        modelLastAddr = 24'h0;
    endtask

    task automatic resetPhase();
        checkMode = 2;
        rst_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            locAddr = locAddr + 4'd1;
        end
        cs_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        clearModel();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checkMode = 1;
    endtask

    task automatic pinLocal(input logic [3:0] idx, input logic [31:0] expected, input string name);
        @(negedge clk);
        locAddr = idx;
        #3;
        checkOutput(name, {32'h0, locRdata}, {32'h0, expected});
    endtask

    // Watchdog so the run always ends
    initial begin
        #3ms;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n   = 1'b0;
        sclk    = 1'b0;
        cs_n    = 1'b1;
        mosi    = 1'b0;
        locAddr = 4'h0;
        clearModel();
        resetPhase();

        // Basic write
        applyStimulus(8'h02, 24'h000005, 32'h789abcde, 64, 20, 1'b0, cap);
        checkOutput("basic_last_cmd", {56'h0, lastCmd}, 64'h02);
        checkOutput("basic_last_addr", {40'h0, lastAddr}, 64'h000005);
        pinLocal(4'd5, 32'h789abcde, "basic_loc5");

        // Read-back
        applyStimulus(8'h03, 24'h000005, 32'h00000000, 64, 20, 1'b0, cap);
        checkOutput("readback_literal", {32'h0, cap[31:0]}, 64'h789abcde);
        checkOutput("readback_hdr_zero", cap[63:32], 64'h0);

        // Out-of-range write/read and unknown command
        applyStimulus(8'h02, 24'h000015, 32'h12345678, 64, 20, 1'b0, cap);
        applyStimulus(8'h03, 24'h000015, 32'h00000000, 64, 20, 1'b0, cap);
        checkOutput("oor_read_literal", {32'h0, cap[31:0]}, 64'h0);
        applyStimulus(8'h02, 24'h000001, 32'h0badf00d, 64, 20, 1'b0, cap);
        applyStimulus(8'hff, 24'h000001, 32'h56789abc, 64, 20, 1'b0, cap);
        pinLocal(4'd1, 32'h0badf00d, "unknown_cmd_loc1");
        checkOutput("unknown_last_cmd", {56'h0, lastCmd}, 64'hff);

        // Abort after bit 40, then a complete write to the same word
        applyStimulus(8'h02, 24'h000003, 32'hdeadbeef, 40, 20, 1'b0, cap);
        pinLocal(4'd3, 32'h0, "abort_loc3");
        checkOutput("abort_last_cmd", {56'h0, lastCmd}, 64'hff);
        applyStimulus(8'h02, 24'h000003, 32'h0000a5a5, 64, 20, 1'b0, cap);
        pinLocal(4'd3, 32'h0000a5a5, "after_abort_loc3");

        // Over-length frame: only the first 64 bits count
        applyStimulus(8'h02, 24'h000007, 32'hcafef00d, 70, 20, 1'b0, cap);
        pinLocal(4'd7, 32'hcafef00d, "overlen_loc7");

        // Back-to-back frames with two sclk periods of cs_n high
        applyStimulus(8'h02, 24'h000008, 32'h13572468, 64, 8, 1'b0, cap);
        applyStimulus(8'h03, 24'h000008, 32'h00000000, 64, 8, 1'b0, cap);
        checkOutput("b2b_read_literal", {32'h0, cap[31:0]}, 64'h13572468);
        pinLocal(4'd8, 32'h13572468, "b2b_loc8");

        // Reset in the middle of an address phase
        applyStimulus(8'h02, 24'h000002, 32'h11112222, 64, 20, 1'b0, cap);
        applyStimulus(8'h02, 24'h000004, 32'h33334444, 20, 0, 1'b1, cap);
        resetPhase();
        pinLocal(4'd5, 32'h0, "post_reset_loc5");
        applyStimulus(8'h02, 24'h000009, 32'ha1b2c3d4, 64, 20, 1'b0, cap);
        applyStimulus(8'h03, 24'h000009, 32'h00000000, 64, 20, 1'b0, cap);
        checkOutput("post_reset_read", {32'h0, cap[31:0]}, 64'ha1b2c3d4);
        checkOutput("post_reset_last_addr", {40'h0, lastAddr}, 64'h000009);

        checkMode = 0;
        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_slave_regfile.md
Name: spi_slave_regfile

Overview:
- SPI responder (target) for the team's SPI master's command frame: 8-bit command, 24-bit address, 32-bit data, MSB first, SPI mode 0.
- Holds a small 32-bit register file that the remote master writes and reads over SPI.
- A local side-band port lets the host-side logic read the register file.
- All SPI inputs are oversampled in the system clock domain. No SPI-clocked flops.

Parameters:
- DEPTH, 16, number of 32-bit words in the register file; power of 2, range 2..256.
- AW, 4, word index width; equals log2(DEPTH).
- CMD_WR, 8'h02, command byte for a write frame.
- CMD_RD, 8'h03, command byte for a read frame.

Ports:
- clk  in  1  system clock; must be at least 8x the sclk frequency.
- rst  in  1  reset, asynchronous, active-low.
- sclk  in  1  SPI clock from the master; idles low.
- cs_n  in  1  SPI chip select, active-low.
- mosi  in  1  master-out data.
- miso  out  1  slave-out data.
- frame_done  out  1  one-clk pulse when a complete 64-bit frame ends.
- busy  out  1  high while a frame is in progress.
- last_cmd  out  8  command byte of the last completed frame.
- last_addr  out  24  address of the last completed frame.
- loc_addr  in  AW  local read index.
- loc_rdata  out  32  combinational read: mem[loc_addr].

Behaviour:
- Reset (rst=0, asynchronous):
  - All memory words = 0.
  - miso=0, frame_done=0, busy=0, last_cmd=0, last_addr=0.
  - FSM goes to IDLE; bit counter = 0.
- Synchronisation and edge detection:
  - sclk, cs_n and mosi each pass through a 2-flop synchroniser.
  - Rising and falling edges of sclk are detected on the synchronised copy (one extra flop).
  - The sclk edge-to-action latency is at most 3 clk.
- FSM states:
  - IDLE: waits for synchronised cs_n=0 → CMD, counter=0, busy=1.
  - CMD: each sclk rising edge samples mosi into the shift register. After bit 8 → ADDR.
  - ADDR: bits 9..32. On the rising edge that samples bit 32:
    - latch the 24-bit address;
    - if cmd==CMD_RD, load the 32-bit output shift register with mem[addr] (or 0 when out of range) and drive its bit 31 on miso in the same clk.
    - Then → DATA.
  - DATA: bits 33..64 are sampled into the data shift register. Each sclk falling edge shifts the output register left by one and miso takes the new MSB; this applies only to read frames, otherwise miso=0. The 64th rising edge → DONE.
  - DONE, entered on the 64th rising edge:
    - if cmd==CMD_WR and the address is in range, mem[addr] <= data, issued in the same clk;
    - last_cmd and last_addr are updated;
    - frame_done is pulsed for one clk;
    - the FSM stays in DONE and ignores further sclk edges until cs_n=1 → IDLE, busy=0, miso=0.
- Address range:
  - In range means addr[23:AW]==0.
  - An out-of-range write is discarded. An out-of-range read returns 32'h0.
- Unknown command: all 64 bits are shifted and the frame completes with frame_done, but there is no memory access and miso stays 0.
- cs_n rises before bit 64 (abort):
  - → IDLE with no write, no frame_done, busy=0, miso=0;
  - last_cmd and last_addr are unchanged.
- miso is 0 whenever cs_n=1 or the state is not DATA of a read. There is no tristate.
- A local read of a word written in the same clk returns the old value; the new value appears the next clk.

Test Plan:
- Reset behaviour: assert rst=0 mid-frame during ADDR, then release. Required response:
  - all outputs are 0;
  - loc_rdata=0 for every loc_addr;
  - the next complete frame is decoded correctly.
- Basic write: clk period 20 ns, sclk period 160 ns. Frame 02 / 000005 / 789abcde. Required response:
  - frame_done pulses once;
  - last_cmd=02, last_addr=000005;
  - with loc_addr=5, loc_rdata=789abcde.
- Read-back: frame 03 / 000005 / 00000000 after the basic write. Required response:
  - the master captures 789abcde on the last 32 rising edges;
  - miso=0 during the command and address bits.
- Out-of-range address and unknown command:
  - write 02 / 000015 / 12345678 → no word changes;
  - read 03 / 000015 → miso returns 0;
  - frame ff / 000001 / 56789abc → frame_done pulses and mem[1] is unchanged.
- Abort: raise cs_n after bit 40 of frame 02 / 000003 / deadbeef. Required response:
  - mem[3] unchanged, no frame_done, busy drops;
  - the following complete frame 02 / 000003 / 0000a5a5 writes mem[3]=0000a5a5.
- Over-length and back-to-back frames:
  - 70 sclk cycles in one frame → only the first 64 bits count;
  - two frames separated by 2 sclk periods of cs_n high → both are decoded.
